kbd_scan_decode: RTL

Consumes the byte stream produced by the PS/2 keyboard receiver (`ps2_keyboard`), pops its FIFO with the `nextdata_n` handshake, and decodes make, break and extended (E0) scan-code sequences into a current-key state. It also keeps a two-digit BCD count of distinct key presses. Its outputs feed the `bcd7seg` display stage directly: `key_code[3:0]` and `key_code[7:4]` for the code, `cnt_bcd` nibbles for the count.

---
 rtl/kbd_scan_decode.sv | 118 +++++++++++
 1 files changed

// File: rtl/kbd_scan_decode.sv
// PS/2 scan-code decoder: pops the receiver FIFO one byte per 3 cycles and tracks
// make/break/E0 sequences into a current-key state plus a BCD press counter.
module kbd_scan_decode (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       ready,
   input  logic       overflow,
   output logic       nextdata_n,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_down,
   output logic       make_pulse,
   output logic [7:0] cnt_bcd,
   output logic       ovf_sticky
);

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {IDLE, POP, WAIT} state_t;

   state_t     state_q, state_d;
   logic       nextdata_n_q, nextdata_n_d;
   logic [7:0] key_code_q, key_code_d;
   logic       key_ext_q, key_ext_d;
   logic       key_down_q, key_down_d;
   logic       make_pulse_q, make_pulse_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ovf_q, ovf_d;
   logic       ext_pend_q, ext_pend_d;
   logic       brk_pend_q, brk_pend_d;
   logic       same_key;

   // A byte naming the key already held with the same E0 qualifier.
   assign same_key = key_down_q && (data == key_code_q) && (ext_pend_q == key_ext_q);

   always_comb begin
      state_d      = state_q;
      nextdata_n_d = 1'b1;
      key_code_d   = key_code_q;
      key_ext_d    = key_ext_q;
      key_down_d   = key_down_q;
      make_pulse_d = 1'b0;
      cnt_d        = cnt_q;
      ovf_d        = ovf_q | overflow;
      ext_pend_d   = ext_pend_q;
      brk_pend_d   = brk_pend_q;
      case (state_q)
         IDLE: begin
            if (ready) begin
               nextdata_n_d = 1'b0;
               state_d      = POP;
               if (data == CODE_EXT) begin
                  ext_pend_d = 1'b1;
               end else if (data == CODE_BRK) begin
                  brk_pend_d = 1'b1;
               end else begin
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
                  if (brk_pend_q) begin
                     if (same_key) key_down_d = 1'b0;
                  end else if (!same_key) begin
                     key_code_d   = data;
                     key_ext_d    = ext_pend_q;
                     key_down_d   = 1'b1;
                     make_pulse_d = 1'b1;
                     if (cnt_q[3:0] == 4'd9) begin
                        cnt_d[3:0] = 4'd0;
                        cnt_d[7:4] = (cnt_q[7:4] == 4'd9) ? 4'd0 : cnt_q[7:4] + 4'd1;
                     end else begin
                        cnt_d[3:0] = cnt_q[3:0] + 4'd1;
                     end
                  end
               end
            end
         end
         POP:     state_d = WAIT;
         WAIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         nextdata_n_q <= 1'b1;
         key_code_q   <= 8'h00;
         key_ext_q    <= 1'b0;
         key_down_q   <= 1'b0;
         make_pulse_q <= 1'b0;
         cnt_q        <= 8'h00;
         ovf_q        <= 1'b0;
         ext_pend_q   <= 1'b0;
         brk_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         nextdata_n_q <= nextdata_n_d;
         key_code_q   <= key_code_d;
         key_ext_q    <= key_ext_d;
         key_down_q   <= key_down_d;
         make_pulse_q <= make_pulse_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         ext_pend_q   <= ext_pend_d;
         brk_pend_q   <= brk_pend_d;
      end
   end

   assign nextdata_n = nextdata_n_q;
   assign key_code   = key_code_q;
   assign key_ext    = key_ext_q;
   assign key_down   = key_down_q;
   assign make_pulse = make_pulse_q;
   assign cnt_bcd    = cnt_q;
   assign ovf_sticky = ovf_q;

endmodule
